// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic PE array: buffers one A/B operand tile
// beat by beat, then streams it into the west/north edges with per-lane skew.
module systolic_feeder #(
  parameter int N        = 4,
  parameter int NUM_BITS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [N*NUM_BITS-1:0]    a_i,
  input  logic [N*NUM_BITS-1:0]    b_i,
  output logic [N*NUM_BITS-1:0]    left_o,
  output logic [N*NUM_BITS-1:0]    top_o,
  output logic                     out_valid_o,
  output logic                     start_o,
  output logic                     done_o
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (N > 1) ? $clog2(2 * N - 1) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] W_MAX  = TW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [TW-1:0]           t_q, t_d;
  logic                    accept;
  logic                    emit_en;
  logic                    emit_first;
  logic                    emit_last;

  logic [N*NUM_BITS-1:0]   left_d, top_d;
  logic [N*NUM_BITS-1:0]   left_q, top_q;
  logic                    out_valid_q, start_q, done_q;

  assign accept = valid_i && ready_o;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (accept && (k_q == K_LAST)) state_d = S_EMIT;
      S_EMIT:  if (t_q == T_LAST)             state_d = S_DONE;
      S_DONE:                                 state_d = S_LOAD;
      default:                                state_d = S_LOAD;
    endcase
  end

  // ready_o depends on state only, never on valid_i.
  always_comb begin
    ready_o    = 1'b0;
    emit_en    = 1'b0;
    emit_first = 1'b0;
    emit_last  = 1'b0;
    case (state_q)
      S_LOAD: ready_o = 1'b1;
      S_EMIT: begin
        emit_en    = 1'b1;
        emit_first = (t_q == '0);
        emit_last  = (t_q == T_LAST);
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- counters
  always_comb begin
    k_d = k_q;
    t_d = t_q;
    if (accept) begin
      k_d = (k_q == K_LAST) ? '0 : k_q + K_ONE;
    end
    if (state_q == S_LOAD) begin
      t_d = '0;
    end else if (emit_en && !emit_last) begin
      t_d = t_q + T_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q <= '0;
      t_q <= '0;
    end else begin
      k_q <= k_d;
      t_q <= t_d;
    end
  end

  // -------------------------------------------------------------- lanes
  // Lane gi holds row gi of A and column gi of B, both indexed by beat k,
  // so the skewed read for lane gi is simply element (t - gi) of each.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam logic [TW-1:0] LO = TW'(gi);

    logic [NUM_BITS-1:0] a_row [N];
    logic [NUM_BITS-1:0] b_col [N];
    logic [TW:0]         diff;
    logic                in_win;
    logic [KW-1:0]       idx;

    always_ff @(posedge clk_i) begin
      if (accept) begin
        a_row[k_q] <= a_i[gi*NUM_BITS +: NUM_BITS];
        b_col[k_q] <= b_i[gi*NUM_BITS +: NUM_BITS];
      end
    end

    // Borrow bit of diff flags t < gi; the upper bound is t - gi <= N-1.
    assign diff   = {1'b0, t_q} - {1'b0, LO};
    assign in_win = emit_en && !diff[TW] && (diff[TW-1:0] <= W_MAX);
    assign idx    = diff[KW-1:0];

    assign left_d[gi*NUM_BITS +: NUM_BITS] = in_win ? a_row[idx] : '0;
    assign top_d[gi*NUM_BITS +: NUM_BITS]  = in_win ? b_col[idx] : '0;
  end

  // ----------------------------------------------------- output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_q      <= '0;
      top_q       <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      left_q      <= left_d;
      top_q       <= top_d;
      out_valid_q <= emit_en;
      start_q     <= emit_first;
      done_q      <= emit_last;
    end
  end

  assign left_o      = left_q;
  assign top_o       = top_q;
  assign out_valid_o = out_valid_q;
  assign start_o     = start_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: scoreboard of skewed slices plus
// a table of hand-computed slices for the canonical 16i+k / 16k+j tile.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int NB = 8;
  localparam int W  = N * NB;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic [W-1:0]  left_o;
  logic [W-1:0]  top_o;
  logic          out_valid_o;
  logic          start_o;
  logic          done_o;

  systolic_feeder #(.N(N), .NUM_BITS(NB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .left_o      (left_o),
    .top_o       (top_o),
    .out_valid_o (out_valid_o),
    .start_o     (start_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] left;
    logic [W-1:0] top;
    logic         start;
    logic         done;
  } exp_t;

  typedef struct {
    int           t;
    logic [W-1:0] left;
    logic [W-1:0] top;
  } vec_t;

  exp_t        sb[$];
  vec_t        vtab[7];
  logic [NB-1:0] ta [N][N];   // ta[i][k]  = A[i][k]
  logic [NB-1:0] tbm[N][N];   // tbm[k][j] = B[k][j]

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  int ov_cnt, start_cyc, done_cyc, cap_n;
  logic [W-1:0] cap_left[8];
  logic [W-1:0] cap_top[8];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop expected slices while streaming, require all-zero otherwise.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (out_valid_o) begin
        exp_t e;
        ov_cnt++;
        if (start_o) start_cyc = cyc;
        if (done_o)  done_cyc  = cyc;
        if (cap_n < 8) begin
          cap_left[cap_n] = left_o;
          cap_top[cap_n]  = top_o;
          cap_n++;
        end
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(out_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("slice_left", 64'(left_o), 64'(e.left));
          check("slice_top", 64'(top_o), 64'(e.top));
          check("slice_flags", {62'd0, start_o, done_o}, {62'd0, e.start, e.done});
        end
      end else begin
        check("idle_zero", {left_o, top_o}, 64'd0);
        check("idle_flags", {62'd0, start_o, done_o}, 64'd0);
      end
    end
  end

  task automatic push_tile();
    for (int t = 0; t <= 2 * N - 2; t++) begin
      exp_t e;
      e.left  = '0;
      e.top   = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i <= N - 1) begin
          e.left[i*NB +: NB] = ta[i][t-i];
          e.top[i*NB +: NB]  = tbm[t-i][i];
        end
      end
      e.start = (t == 0);
      e.done  = (t == 2 * N - 2);
      sb.push_back(e);
    end
  endtask

  task automatic fill_canon();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ta[i][k]  = NB'(16 * i + k);
        tbm[i][k] = NB'(16 * i + k);
      end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ta[i][k]  = NB'($urandom_range(1, 255));
        tbm[i][k] = NB'($urandom_range(1, 255));
      end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      a_i[i*NB +: NB] = ta[i][k];
      b_i[i*NB +: NB] = tbm[k][i];
    end
  endtask

  // Returns c = cycle in which the last beat was accepted.
  task automatic load_tile(input int nbeats, input bit gappy, output int c);
    int g;
    c = 0;
    for (int k = 0; k < nbeats; k++) begin
      valid_i = 1'b1;
      drive_beat(k);
      g = 0;
      while (!ready_o && g < 100) begin
        @(posedge clk_i); #1;
        g++;
      end
      if (g >= 100) begin
        check("load_ready_timeout", 64'(ready_o), 64'd1);
        valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
      c = cyc - 1;
      if (gappy) begin
        valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b0;
    if (nbeats == N) push_tile();
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid_o) && g < 60) begin
      @(posedge clk_i); #1;
      g++;
    end
    if (g >= 60) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_table(input string tag);
    for (int v = 0; v < 7; v++) begin
      check({tag, "_tab_left"}, 64'(cap_left[vtab[v].t]), 64'(vtab[v].left));
      check({tag, "_tab_top"}, 64'(cap_top[vtab[v].t]), 64'(vtab[v].top));
    end
  endtask

  initial begin
    int c, n, g;
    int acc[8];
    bit rdy;

    #2_000_000;
    $display("FAIL global_timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, n, g;
    int acc[8];
    bit rdy;

    // Hand-computed slices for A[i][k]=16i+k, B[k][j]=16k+j (lane 0 in LSBs).
    vtab[0] = '{t: 0, left: 32'h00000000, top: 32'h00000000};
    vtab[1] = '{t: 1, left: 32'h00001001, top: 32'h00000110};
    vtab[2] = '{t: 2, left: 32'h00201102, top: 32'h00021120};
    vtab[3] = '{t: 3, left: 32'h30211203, top: 32'h03122130};
    vtab[4] = '{t: 4, left: 32'h31221300, top: 32'h13223100};
    vtab[5] = '{t: 5, left: 32'h32230000, top: 32'h23320000};
    vtab[6] = '{t: 6, left: 32'h33000000, top: 32'h33000000};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("reset_data", {left_o, top_o}, 64'd0);
    check("reset_flags", {61'd0, out_valid_o, start_o, done_o}, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd1);
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle_no_start", 64'(start_o), 64'd0);
      check("idle_ready", 64'(ready_o), 64'd1);
      @(posedge clk_i); #1;
    end

    // Canonical tile, back-to-back beats.
    fill_canon();
    cap_n = 0; ov_cnt = 0; start_cyc = -1; done_cyc = -1;
    load_tile(N, 1'b0, c);
    wait_drain();
    check("canon_ov_cycles", 64'(ov_cnt), 64'd7);
    check("canon_start_lat", 64'(start_cyc - c), 64'd2);
    check("canon_done_lat", 64'(done_cyc - c), 64'(2 * N));
    check_table("canon");

    // Same tile with valid_i toggling.
    cap_n = 0; ov_cnt = 0; start_cyc = -1;
    load_tile(N, 1'b1, c);
    wait_drain();
    check("gappy_start_lat", 64'(start_cyc - c), 64'd2);
    check("gappy_ov_cycles", 64'(ov_cnt), 64'd7);
    check_table("gappy");

    // valid_i held high across two tiles.
    fill_rand();
    n = 0; g = 0; acc[3] = 1 << 30;
    valid_i = 1'b1;
    while (n < 2 * N && g < 100) begin
      drive_beat(n % N);
      rdy = ready_o;
      if (n == N && cyc > acc[3])
        check("busy_ready", 64'(ready_o), 64'(cyc - acc[3] >= 9));
      @(posedge clk_i); #1;
      g++;
      if (rdy) begin
        acc[n] = cyc - 1;
        n++;
        if (n == N) begin
          push_tile();
          fill_rand();
        end
        if (n == 2 * N) push_tile();
      end
    end
    valid_i = 1'b0;
    check("b2b_all_beats", 64'(n), 64'(2 * N));
    if (n == 2 * N) check("b2b_gap", 64'(acc[N] - acc[N-1]), 64'd9);
    wait_drain();

    // Reset during EMIT at t=2.
    fill_rand();
    load_tile(N, 1'b0, c);          // now in cycle c+1
    @(posedge clk_i); #1;           // c+2
    @(posedge clk_i); #1;           // c+3: EMIT, t=2
    rst_i = 1'b1;
    @(posedge clk_i); #1;           // c+4
    check("emit_rst_data", {left_o, top_o}, 64'd0);
    check("emit_rst_flags", {61'd0, out_valid_o, start_o, done_o}, 64'd0);
    check("emit_rst_ready", 64'(ready_o), 64'd1);
    sb.delete();
    rst_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end
    fill_rand();
    start_cyc = -1;
    load_tile(N, 1'b0, c);
    wait_drain();
    check("post_rst_start_lat", 64'(start_cyc - c), 64'd2);

    // Reset after a partial tile of 2 beats.
    fill_rand();
    load_tile(2, 1'b0, c);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("partial_rst_ready", 64'(ready_o), 64'd1);
    fill_rand();
    start_cyc = -1;
    load_tile(N, 1'b0, c);
    wait_drain();
    check("partial_start_lat", 64'(start_cyc - c), 64'd2);

    // A few random tiles with random beat gaps.
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      load_tile(N, 1'($urandom_range(0, 1)), c);
      wait_drain();
    end

    repeat (3) begin @(posedge clk_i); #1; end
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Edge feeder for the N×N PE array. It buffers one operand tile: N beats, each carrying one column of A and one row of B. It then streams the tile into the array's west edge (e_w[i][0]) and north edge (n_s[0][j]), with lane i/j delayed by i/j cycles (systolic skew). Lanes outside their active window are zero-filled, so PEs accumulate zeros rather than undefined values. It pulses `start_o` to the controller when streaming begins and `done_o` when the last skewed element has been presented.

## Interface
Parameters:
- `N`, default `pkg::N`: array dimension; tile depth in beats.
- `NUM_BITS`, default `pkg::NUM_BITS`: operand width.

Ports:
- `clk_i`  in  1  clock; single clock domain, all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  feeder can accept a beat.
- `a_i`  in  N × NUM_BITS  column k of A; `a_i[i]` = A[i][k].
- `b_i`  in  N × NUM_BITS  row k of B; `b_i[j]` = B[k][j].
- `left_o`  out  N × NUM_BITS  to `e_w[i][0]`, registered.
- `top_o`  out  N × NUM_BITS  to `n_s[0][j]`, registered.
- `out_valid_o`  out  1  high while the skewed stream is on `left_o`/`top_o`.
- `start_o`  out  1  one-cycle pulse; first stream cycle.
- `done_o`  out  1  one-cycle pulse; last stream cycle.

## Operation
- Storage: A buffer N×N and B buffer N×N, NUM_BITS each. Storage is not reset.
- Counters: beat counter `k` (0..N-1, clog2(N) bits). Emit counter `t` (0..2N-2, clog2(2N-1) bits).
- FSM states: LOAD, EMIT, DONE. Reset state is LOAD.
- LOAD:
  - `ready_o`=1.
  - On `valid_i && ready_o`: write `a_i` to A column k and `b_i` to B row k, then k++.
  - Gaps in `valid_i` are allowed; nothing advances during a gap.
  - When a beat is accepted with k==N-1: k←0, t←0, go to EMIT.
- EMIT:
  - `ready_o`=0; `valid_i` is ignored.
  - Each cycle registers the skew slice for the current t, then t++.
  - When t==2N-2: go to DONE.
- DONE: lasts one cycle, then LOAD. `ready_o`=0.
- Skew slice for t:
  - `left_o[i]` = A[i][t-i] if 0 ≤ t-i ≤ N-1, else 0.
  - `top_o[j]` = B[t-j][j] if 0 ≤ t-j ≤ N-1, else 0.
- Outside EMIT, the next-cycle `left_o`/`top_o` are all zero.
- No arithmetic on data: values pass through bit-exact. Zero fill is all-zero NUM_BITS.

## Timing
- Reset values: `left_o`/`top_o` all 0; `out_valid_o`, `start_o`, `done_o` = 0; `ready_o`=1 (LOAD); k=t=0.
- Reset asserted in any state takes effect at the next edge. A partial tile or in-flight stream is discarded, and outputs are zero from the following cycle.
- Let c be the cycle the final (N-th) beat is accepted:
  - c+1: EMIT, t=0.
  - c+2: registered slice t=0 on outputs; `out_valid_o`=1 and `start_o`=1.
  - c+2N: slice t=2N-2 on outputs; `out_valid_o`=1 and `done_o`=1. State is DONE.
  - c+2N+1: outputs return to 0, `out_valid_o`=0, state LOAD, `ready_o`=1.
- `out_valid_o` is high for exactly 2N-1 consecutive cycles per tile.
- `ready_o` is combinational from state only; it has no path from `valid_i`.
- Throughput: one tile per N + 2N minimum cycles (N load + 2N-1 emit + 1 done).
- N=1 edge case: EMIT lasts one cycle, and `start_o` and `done_o` pulse in the same cycle.

## Test plan
- N=4, NUM_BITS=8. Reset held 3 cycles. Check all outputs 0, `ready_o`=1, and no `start_o` for 10 idle cycles.
- Load A[i][k]=16i+k and B[k][j]=16k+j with `valid_i` every cycle.
  - At output cycle t=3: `left_o`={3,0x12,0x21,0x30} and `top_o`={0x30,0x21,0x12,0x03}.
  - At t=0: `left_o`={0,0,0,0} except `left_o[0]`=0x00; `top_o[1..3]`=0.
  - `out_valid_o` high exactly 7 cycles.
- Same tile with `valid_i` toggling 1,0,1,0: stream identical to the back-to-back case, and `start_o` arrives 2 cycles after the 4th accepted beat.
- Hold `valid_i`=1 continuously across two tiles:
  - `ready_o`=0 during EMIT/DONE.
  - The second tile's first beat is accepted 9 cycles after the first tile's last beat.
  - No beat is lost or duplicated.
- Assert `rst_i` at EMIT t=2: next cycle outputs all 0, `out_valid_o`=0, and no `done_o`. A following full tile streams correctly.
- Assert `rst_i` after 2 of 4 beats: the partial tile is discarded, and the next 4 beats form a fresh tile (verify values).
